// File: rtl/fb_pkg.sv
// Shared constants, logo bitmap and state type for the NES frame buffer write-port arbiter.
// The logo bitmap is referenced only when FB_LOGO_EN is defined.
package fb_pkg;

    localparam int FB_W      = 256;
    localparam int FB_H      = 240;
    localparam int FB_ADDR_W = 16;

    localparam int LOGO_X0 = 96;
    localparam int LOGO_Y0 = 212;
    localparam int LOGO_W  = 65;
    localparam int LOGO_H  = 13;

    // Row 0 is the top logo row; bit 64 of each row is its leftmost pixel.
    localparam logic [LOGO_W-1:0] LOGO_ROM [LOGO_H] = '{
        65'h1_E3C7_1E38_F1C7_8E3F,
        65'h1_0844_2140_8A24_4821,
        65'h1_0844_2140_8A24_4821,
        65'h1_0844_2140_8A24_4821,
        65'h1_E847_3E38_8BC4_4E3F,
        65'h1_0844_2004_8A24_4821,
        65'h1_0844_2004_8A24_4821,
        65'h1_0844_2004_8A24_4821,
        65'h1_0FC7_3E38_F1C7_8FE1,
        65'h0_0000_0000_0000_0000,
        65'h1_FFFF_FFFF_FFFF_FFFF,
        65'h0_0000_0000_0000_0000,
        65'h1_5555_5555_5555_5555
    };

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } fb_state_t;

    function automatic logic [FB_ADDR_W-1:0] xy_addr(input logic [7:0] x, input logic [7:0] y);
        return {y, x};
    endfunction

endpackage

// File: rtl/fb_fill_seq.sv
// Fill address sequencer: raster x/y counter over the visible area, latched fill colour and
// optional logo overlay (FB_LOGO_EN). start restarts at 0x0000; step advances one pixel.
module fb_fill_seq
    import fb_pkg::*;
#(
    parameter logic [5:0] DEFAULT_BG = 6'd13,
    parameter logic [5:0] LOGO_COLOR = 6'd4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 step,
    input  logic [5:0]           fill_color,
    output logic [FB_ADDR_W-1:0] addr,
    output logic [5:0]           data,
    output logic                 last
);

    logic [7:0] x_q, x_d;
    logic [7:0] y_q, y_d;
    logic [5:0] color_q, color_d;

    assign last = (x_q == 8'(FB_W - 1)) && (y_q == 8'(FB_H - 1));
    assign addr = xy_addr(x_q, y_q);

    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        color_d = color_q;
        if (start) begin
            x_d     = 8'd0;
            y_d     = 8'd0;
            color_d = fill_color;
        end else if (step) begin
            if (x_q == 8'(FB_W - 1)) begin
                x_d = 8'd0;
                y_d = last ? 8'd0 : y_q + 8'd1;
            end else begin
                x_d = x_q + 8'd1;
            end
        end
    end

    // After reset the sequencer is already positioned for the default-colour fill.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q     <= 8'd0;
            y_q     <= 8'd0;
            color_q <= DEFAULT_BG;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            color_q <= color_d;
        end
    end

`ifdef FB_LOGO_EN
    logic [7:0] dx;
    logic [7:0] dy;
    logic       in_logo;
    logic       logo_bit;

    always_comb begin
        dx       = x_q - 8'(LOGO_X0);
        dy       = y_q - 8'(LOGO_Y0);
        in_logo  = (x_q >= 8'(LOGO_X0)) && (x_q <= 8'(LOGO_X0 + LOGO_W - 1)) &&
                   (y_q >= 8'(LOGO_Y0)) && (y_q <= 8'(LOGO_Y0 + LOGO_H - 1));
        logo_bit = 1'b0;
        if (in_logo) begin
            logo_bit = LOGO_ROM[dy[3:0]][7'(LOGO_W - 1) - dx[6:0]];
        end
        data = (in_logo && logo_bit) ? LOGO_COLOR : color_q;
    end
`else
    logic unused_logo;

    assign data        = color_q;
    assign unused_logo = ^LOGO_COLOR;
`endif

endmodule

// File: rtl/fb_port_arbiter.sv
// Write-port scheduler for the 256x240x6 NES frame buffer: NES pixels, fill sequencer, host.
// Optional logo overlay in fills is enabled by defining FB_LOGO_EN.
module fb_port_arbiter
    import fb_pkg::*;
#(
    parameter logic [5:0] DEFAULT_BG = 6'd13,
    parameter logic [5:0] LOGO_COLOR = 6'd4
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [5:0]           color,
    input  logic [8:0]           cycle,
    input  logic [8:0]           scanline,
    input  logic                 fill_req,
    input  logic [5:0]           fill_color,
    input  logic                 host_valid,
    output logic                 host_ready,
    input  logic [15:0]          host_addr,
    input  logic [5:0]           host_data,
    output logic                 fb_we,
    output logic [FB_ADDR_W-1:0] fb_addr,
    output logic [5:0]           fb_wdata,
    output logic                 busy,
    output logic [7:0]           drop_cnt
);

    fb_state_t state_q, state_d;

    logic [8:0]           r_scanline_q, r_scanline_d;
    logic [8:0]           r_cycle_q, r_cycle_d;
    logic                 fb_we_q, fb_we_d;
    logic [FB_ADDR_W-1:0] fb_addr_q, fb_addr_d;
    logic [5:0]           fb_wdata_q, fb_wdata_d;
    logic                 busy_q, busy_d;
    logic [7:0]           drop_cnt_q, drop_cnt_d;

    logic                 pix_hit;
    logic                 fill_start;
    logic                 fill_step;
    logic [FB_ADDR_W-1:0] fill_addr;
    logic [5:0]           fill_data;
    logic                 fill_last;

    fb_fill_seq #(
        .DEFAULT_BG (DEFAULT_BG),
        .LOGO_COLOR (LOGO_COLOR)
    ) u_fill_seq (
        .clk        (clk),
        .rst_n      (resetn),
        .start      (fill_start),
        .step       (fill_step),
        .fill_color (fill_color),
        .addr       (fill_addr),
        .data       (fill_data),
        .last       (fill_last)
    );

    // A pixel is new whenever the PPU position moved and lies inside the visible area.
    assign r_scanline_d = scanline;
    assign r_cycle_d    = cycle;
    assign pix_hit      = ((scanline != r_scanline_q) || (cycle != r_cycle_q)) &&
                          (scanline < 9'(FB_H)) && !cycle[8];

    // Host handshake: a write is taken in any cycle where host_valid && host_ready; host_ready
    // is combinational and only high in RUN without a pixel, so a refused request just waits.
    always_comb begin
        state_d    = state_q;
        fb_we_d    = 1'b0;
        fb_addr_d  = fb_addr_q;
        fb_wdata_d = fb_wdata_q;
        busy_d     = busy_q;
        drop_cnt_d = drop_cnt_q;
        host_ready = 1'b0;
        fill_start = 1'b0;
        fill_step  = 1'b0;
        case (state_q)
            FILL: begin
                fill_step  = 1'b1;
                fb_we_d    = 1'b1;
                fb_addr_d  = fill_addr;
                fb_wdata_d = fill_data;
                if (pix_hit && (drop_cnt_q != 8'hFF)) begin
                    drop_cnt_d = drop_cnt_q + 8'd1;
                end
                if (fill_last) begin
                    state_d = RUN;
                    busy_d  = 1'b0;
                end
            end
            RUN: begin
                host_ready = !pix_hit;
                if (pix_hit) begin
                    fb_we_d    = 1'b1;
                    fb_addr_d  = xy_addr(cycle[7:0], scanline[7:0]);
                    fb_wdata_d = color;
                end else if (host_valid) begin
                    fb_we_d    = 1'b1;
                    fb_addr_d  = host_addr;
                    fb_wdata_d = host_data;
                end
                // The write decided above still lands; the fill begins next cycle.
                if (fill_req) begin
                    state_d    = FILL;
                    busy_d     = 1'b1;
                    fill_start = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= FILL;
            r_scanline_q <= 9'd0;
            r_cycle_q    <= 9'd0;
            fb_we_q      <= 1'b0;
            fb_addr_q    <= '0;
            fb_wdata_q   <= 6'd0;
            busy_q       <= 1'b1;
            drop_cnt_q   <= 8'd0;
        end else begin
            state_q      <= state_d;
            r_scanline_q <= r_scanline_d;
            r_cycle_q    <= r_cycle_d;
            fb_we_q      <= fb_we_d;
            fb_addr_q    <= fb_addr_d;
            fb_wdata_q   <= fb_wdata_d;
            busy_q       <= busy_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    assign fb_we    = fb_we_q;
    assign fb_addr  = fb_addr_q;
    assign fb_wdata = fb_wdata_q;
    assign busy     = busy_q;
    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Directed bench for fb_port_arbiter: expected frame buffer writes are queued as stimulus is
// issued, and a negedge monitor pops and compares every write the DUT presents.
module tb_fb_port_arbiter;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [5:0]  color = 6'd0;
    logic [8:0]  cycle = 9'd0;
    logic [8:0]  scanline = 9'd0;
    logic        fill_req = 1'b0;
    logic [5:0]  fill_color = 6'd0;
    logic        host_valid = 1'b0;
    logic        host_ready;
    logic [15:0] host_addr = 16'd0;
    logic [5:0]  host_data = 6'd0;
    logic        fb_we;
    logic [15:0] fb_addr;
    logic [5:0]  fb_wdata;
    logic        busy;
    logic [7:0]  drop_cnt;

    int          n_checks = 0;
    int          n_pass = 0;
    logic [21:0] exp_q[$];
    logic [21:0] mon_e;

    always #5 clk = ~clk;

    fb_port_arbiter dut (
        .clk        (clk),
        .resetn     (resetn),
        .color      (color),
        .cycle      (cycle),
        .scanline   (scanline),
        .fill_req   (fill_req),
        .fill_color (fill_color),
        .host_valid (host_valid),
        .host_ready (host_ready),
        .host_addr  (host_addr),
        .host_data  (host_data),
        .fb_we      (fb_we),
        .fb_addr    (fb_addr),
        .fb_wdata   (fb_wdata),
        .busy       (busy),
        .drop_cnt   (drop_cnt)
    );

    function automatic logic [5:0] fill_exp(input logic [15:0] a, input logic [5:0] bg);
`ifdef FB_LOGO_EN
        int x;
        int y;
        x = int'(a[7:0]);
        y = int'(a[15:8]);
        if (x >= 96 && x <= 160 && y >= 212 && y <= 224) begin
            if (fb_pkg::LOGO_ROM[y - 212][64 - (x - 96)]) return 6'd4;
        end
`endif
        return bg;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_fill(input int first, input int last, input logic [5:0] bg);
        for (int a = first; a <= last; a++) exp_q.push_back({16'(a), fill_exp(16'(a), bg)});
    endtask

    task automatic push_write(input logic [15:0] a, input logic [5:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_fb_we"}, 32'(fb_we), 32'd0);
        check({tag, "_fb_addr"}, 32'(fb_addr), 32'd0);
        check({tag, "_fb_wdata"}, 32'(fb_wdata), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        check({tag, "_host_ready"}, 32'(host_ready), 32'd0);
        check({tag, "_drop_cnt"}, 32'(drop_cnt), 32'd0);
    endtask

    // Monitor: every presented write must match the head of the expected queue.
    always @(negedge clk) begin
        if (fb_we === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL write_unexpected: got addr=%h data=%h expected no write", fb_addr, fb_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                if ({fb_addr, fb_wdata} === mon_e) n_pass++;
                else $display("FAIL write: got addr=%h data=%h expected addr=%h data=%h",
                              fb_addr, fb_wdata, mon_e[21:6], mon_e[5:0]);
            end
        end
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: got time limit expected summary, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;

        // Reset values and the fill that follows reset.
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("rst");
        push_fill(0, 16'hEFFF, 6'd13);
        resetn = 1'b1;
        n = 0;
        while (busy !== 1'b0 && n < 70000) begin
            step();
            n++;
            if (n == 1) begin
                check("first_fill_we", 32'(fb_we), 32'd1);
                check("first_fill_addr", 32'(fb_addr), 32'd0);
                check("fill_host_ready", 32'(host_ready), 32'd0);
            end
            fill_req   = (n == 100);
            fill_color = 6'd2;
        end
        fill_req = 1'b0;
        check("fill_len", 32'(n), 32'd61440);
        check("fill_last_addr", 32'(fb_addr), 32'hEFFF);
        check("busy_fall", 32'(busy), 32'd0);
        check("run_host_ready", 32'(host_ready), 32'd1);

        // Pixel stream on scanline 5, then positions outside the visible area.
        scanline = 9'd5;
        color    = 6'h21;
        for (int c = 0; c < 4; c++) begin
            cycle = 9'(c);
            push_write(16'h0500 + 16'(c), 6'h21);
            step();
        end
        scanline = 9'd240;
        #2;
        check("ready_sl240", 32'(host_ready), 32'd1);
        step();
        scanline = 9'd5;
        cycle    = 9'd256;
        #2;
        check("ready_cyc256", 32'(host_ready), 32'd1);
        step();
        step();
        check("idle_we", 32'(fb_we), 32'd0);
        check("hold_addr", 32'(fb_addr), 32'h0503);
        check("hold_data", 32'(fb_wdata), 32'h21);
        check("pixels_drained", 32'(exp_q.size()), 32'd0);

        // Contention: pixel every other cycle, host held until an idle cycle.
        for (int k = 0; k < 3; k++) begin
            scanline   = 9'd6;
            cycle      = 9'(k);
            color      = 6'h10 + 6'(k);
            host_valid = 1'b1;
            host_addr  = 16'h1234 + 16'(k);
            host_data  = 6'd7 + 6'(k);
            #2;
            check("ready_on_pix", 32'(host_ready), 32'd0);
            push_write(16'h0600 + 16'(k), 6'h10 + 6'(k));
            step();
            #2;
            check("ready_idle", 32'(host_ready), 32'd1);
            push_write(16'h1234 + 16'(k), 6'd7 + 6'(k));
            step();
        end
        host_valid = 1'b0;

        // Requested fill together with a pixel; drops during the fill.
        cycle      = 9'd3;
        color      = 6'h2A;
        fill_req   = 1'b1;
        fill_color = 6'd2;
        #2;
        check("ready_fillreq_pix", 32'(host_ready), 32'd0);
        check("busy_before_req", 32'(busy), 32'd0);
        push_write(16'h0603, 6'h2A);
        push_fill(0, 16'h4000, 6'd2);
        step();
        fill_req   = 1'b0;
        fill_color = 6'd0;
        #2;
        check("busy_rise", 32'(busy), 32'd1);
        check("fill2_host_ready", 32'(host_ready), 32'd0);
        for (int i = 0; i < 300; i++) begin
            scanline = 9'd7;
            cycle    = 9'(i % 256);
            step();
            if (i == 99) check("drop_100", 32'(drop_cnt), 32'd100);
        end
        check("drop_sat", 32'(drop_cnt), 32'd255);

        // Reset in the middle of the fill.
        n = 0;
        while (!(fb_we === 1'b1 && fb_addr === 16'h4000) && n < 20000) begin
            step();
            n++;
        end
        check("midfill_reached", 32'(fb_addr), 32'h4000);
        @(negedge clk);
        #1;
        resetn = 1'b0;
        #1;
        check_reset_vals("midrst");
        check("midfill_drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        scanline = 9'd0;
        cycle    = 9'd0;
        color    = 6'd0;
        push_fill(0, 15, 6'd13);
        step();
        step();
        resetn = 1'b1;
        for (int i = 0; i < 16; i++) step();
        check("restart_addr", 32'(fb_addr), 32'd15);
        check("restart_busy", 32'(busy), 32'd1);
        @(negedge clk);
        #1;
        resetn = 1'b0;
        check("restart_drained", 32'(exp_q.size()), 32'd0);
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fb_port_arbiter.md
# fb_port_arbiter

Scheduler and arbiter for the write port of the 256×240×6-bit NES frame buffer. It owns three write sources:
- the NES pixel stream, which has highest priority;
- an internal fill sequencer that clears the buffer to a background colour, optionally with a logo, after reset or on request;
- a host write port with valid/ready flow control, used by the loader/OSD.

It sits in the `clk` (NES clock) domain and drives the frame buffer's port A. The HDMI read side is unaffected.

## Interface
Parameters:
- `DEFAULT_BG`, 6'd13 — fill colour used for the fill that follows reset.
- `LOGO_COLOR`, 6'd4 — colour of logo pixels (used only with `FB_LOGO_EN`).

Ports:
- `clk`  in  1  NES clock; the only clock.
- `resetn`  in  1  reset, asynchronous and active-low.
- `color`  in  6  NES pixel colour index.
- `cycle`  in  9  NES PPU cycle.
- `scanline`  in  9  NES PPU scanline.
- `fill_req`  in  1  single-cycle pulse; starts a fill.
- `fill_color`  in  6  background colour for a requested fill.
- `host_valid`  in  1  host write request.
- `host_ready`  out  1  host write accepted this cycle when high together with `host_valid`.
- `host_addr`  in  16  host write address, `{y[7:0], x[7:0]}`.
- `host_data`  in  6  host write data.
- `fb_we`  out  1  frame buffer write enable.
- `fb_addr`  out  16  frame buffer write address.
- `fb_wdata`  out  6  frame buffer write data.
- `busy`  out  1  high while a fill is in progress.
- `drop_cnt`  out  8  count of NES pixels dropped during fills; saturates at 255.

## Operation
States are `FILL` and `RUN`. Reset enters `FILL` with the fill colour set to `DEFAULT_BG`.

Pixel detect (`pix_hit`):
- `r_scanline` and `r_cycle` register `scanline` and `cycle` every cycle.
- `pix_hit` is true when (`scanline != r_scanline` or `cycle != r_cycle`) and `scanline < 240` and `cycle[8] == 0`.
- The write address is `{scanline[7:0], cycle[7:0]}` and the data is `color`.

In `FILL`:
- One write per cycle, x fastest, addresses 0x0000 through 0xEFFF (61,440 writes).
- Data is the latched fill colour.
- `pix_hit` events are dropped, and each one increments `drop_cnt`, saturating at 255.
- `host_ready = 0`.
- `fill_req` is ignored.

After the write to 0xEFFF the block moves to `RUN`.

In `RUN`:
- Priority is `pix_hit` first, then host.
- `host_ready = !pix_hit`. This is combinational from the registered `r_*` values and the current inputs.
- Host data is never buffered inside the block; a host request that is not accepted simply waits.
- On `fill_req`:
  - `fill_color` is latched and `FILL` starts on the next cycle at address 0.
  - A `pix_hit` or host handshake in the same cycle as `fill_req` still completes.

`drop_cnt` is cleared by reset only.

## Timing
- **Write latency:** every write appears on `fb_we`/`fb_addr`/`fb_wdata` exactly one cycle after its decision cycle. All three outputs are registered.
- **No-write cycles:** `fb_we` is 0, and `fb_addr`/`fb_wdata` hold their last values.
- **Reset values:**

  | Output | Reset value |
  |---|---|
  | `fb_we` | 0 |
  | `fb_addr` | 0 |
  | `fb_wdata` | 0 |
  | `busy` | 1 |
  | `host_ready` | 0 |
  | `drop_cnt` | 0 |
  | `r_scanline`, `r_cycle` | 0 |

- **First fill after reset:** the first fill write appears on `fb_we` in the first cycle after `resetn` deasserts.
- **`busy` timing:**
  - It is registered and tracks the state: 1 in `FILL`, 0 in `RUN`.
  - It falls in the same cycle that the 0xEFFF write is presented on `fb_we`.
  - It rises the cycle after a `fill_req` is accepted.
- **Fill duration:** 61,440 consecutive cycles, with no gaps.
- **Reset mid-fill:** asynchronous reset aborts any fill immediately. The fill then restarts from 0x0000 using `DEFAULT_BG`.

## Configuration
`FB_LOGO_EN`:
- **Defined:** during any fill, pixels with x in 96..160 and y in 212..224 take `LOGO_COLOR` when `LOGO_ROM[y-212][64-(x-96)]` is 1.
  - The ROM has 13 rows of 65 bits. The MSB of each row is the leftmost pixel.
- **Undefined:** every fill pixel is the fill colour, and the logo ROM is not instantiated.

## Structure
Package `fb_pkg` holds:
- `FB_W`=256, `FB_H`=240, `FB_ADDR_W`=16;
- `LOGO_X0`=96, `LOGO_Y0`=212, `LOGO_W`=65, `LOGO_H`=13, `LOGO_ROM`;
- the state enum `fb_state_t` {`FILL`, `RUN`}.

Sub-module `fb_fill_seq` contains the x/y counter, the end-of-fill flag and the logo lookup. It outputs the address, the data and `last`.

## Test plan
1. **Reset fill:** release `resetn`, hold NES idle. Expect 61,440 consecutive writes, all data 13, the last at 0xEFFF; `busy` falls with that last write.
2. **`FB_LOGO_EN` build:** check the write at (x=96, y=212) = 4 and the write at (x=100, y=212) = 13.
3. **Pixel stream:** after the fill, step `cycle` 0..3 on scanline 5 with `color`=0x21. Expect writes at 0x0500–0x0503 with data 0x21, each one cycle later. Step to `scanline`=240 and to `cycle`=256: expect no write.
4. **Contention:** hold `host_valid` (addr 0x1234, data 7) while pixels change every other cycle. `host_ready` is low on `pix_hit` cycles; the host write lands on the first idle cycle, and no pixel write is lost.
5. **Requested fill:** pulse `fill_req` with `fill_color`=2 together with a pixel change. The pixel is written, then the fill starts the next cycle with data 2. 300 pixel changes during the fill give `drop_cnt`=255.
6. **Reset mid-fill:** assert `resetn`=0 at fill address 0x4000. Outputs return to reset values immediately, and the fill restarts at 0x0000 with data 13.
